// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns one core load/store request into a handshaked RAM
// transaction with lane steering, load extension, legality checks and an ack timeout.
module lsu_mem_ctrl #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned AW      = 10,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [AW-1:0]            req_addr,
    input  logic [XLEN-1:0]          req_wdata,
    output logic                     rsp_valid,
    output logic [XLEN-1:0]          rsp_rdata,
    output logic                     rsp_err,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [AW-$clog2(XLEN/8)-1:0] mem_addr,
    output logic [XLEN/8-1:0]        mem_be,
    output logic [XLEN-1:0]          mem_wdata,
    input  logic                     mem_ack,
    input  logic [XLEN-1:0]          mem_rdata
);

    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OFFW = $clog2(NB);
    localparam int unsigned CW   = 8;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            err_d;
    logic            accept;
    logic            we_q, uns_q;
    logic [1:0]      size_q;
    logic [OFFW-1:0] off_q;
    logic [CW-1:0]   cnt_q;

    logic [1:0]      size_in;
    logic [OFFW-1:0] off_in;
    logic [NB-1:0]   mask_in, be_in;
    logic [2:0]      align_in;
    logic            misal_in, illegal_in;

    logic [XLEN-1:0] shifted, keep, ext;
    logic            sign;

    assign accept  = req_valid && req_ready && (state_q == IDLE);
    assign size_in = req_funct3[1:0];
    assign off_in  = req_addr[OFFW-1:0];

    // Request decode: lane mask, alignment and funct3 legality
    always_comb begin
        mask_in = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            mask_in[i] = (i < (32'd1 << size_in));
        end
        be_in      = mask_in << off_in;
        align_in   = 3'((4'd1 << size_in) - 4'd1);
        misal_in   = |(req_addr[2:0] & align_in);
        illegal_in = ((size_in == 2'd3) && (XLEN == 32))
                   || (req_funct3[2] && req_we)
                   || (req_funct3[2] && (32'(size_in) == OFFW));
    end

    // Load data: shift lane down, keep access width, sign/zero extend the rest
    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        keep    = '0;
        for (int unsigned i = 0; i < XLEN; i++) begin
            keep[i] = (i < (32'd8 << size_q));
        end
        case (size_q)
            2'd0:    sign = shifted[7];
            2'd1:    sign = shifted[15];
            2'd2:    sign = shifted[31];
            default: sign = shifted[XLEN-1];
        endcase
        ext = (shifted & keep) | ({XLEN{sign & ~uns_q}} & ~keep);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (illegal_in || misal_in) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered outputs and latched request fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            size_q    <= '0;
            off_q     <= '0;
            cnt_q     <= '0;
        end else begin
            req_ready <= (state_d == IDLE);
            mem_req   <= (state_d == ACCESS);
            rsp_valid <= (state_d == RESP);
            rsp_err   <= err_d;
            rsp_rdata <= (state_q == ACCESS && mem_ack && !we_q) ? ext : '0;
            if (state_q == ACCESS) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (accept) begin
                we_q      <= req_we;
                uns_q     <= req_funct3[2];
                size_q    <= size_in;
                off_q     <= off_in;
                cnt_q     <= '0;
                mem_addr  <= req_addr[AW-1:OFFW];
                mem_wdata <= req_wdata << {off_in, 3'b000};
                mem_we    <= req_we && (state_d == ACCESS);
                mem_be    <= (state_d == ACCESS) ? be_in : '0;
            end else if (state_d != ACCESS) begin
                mem_we <= 1'b0;
                mem_be <= '0;
            end
        end
    end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Parametrised load/store unit for the multi-cycle core. It sits between the core control FSM and the data RAM, and turns a single load or store request into a handshaked memory transaction. It handles byte/half/word (and double when XLEN=64) access, sign and zero extension, byte enables, misalignment detection and a memory-ack timeout.

## Interface
- XLEN, default 32: data width; legal values are 32 and 64. NB = XLEN/8 byte lanes; OFFW = log2(NB).
- AW, default 10: byte-address width.
- TIMEOUT, default 15: maximum number of cycles mem_req is held without mem_ack before an error is reported. Legal range 1..255.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request strobe from the core.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3. Bits [1:0] = size (0 B, 1 H, 2 W, 3 D). Bit [2] = unsigned load.
- req_addr  in  AW  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err  out  1  qualifies rsp_valid: misaligned access, illegal funct3, or timeout.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write.
- mem_addr  out  AW-OFFW  word address, equal to req_addr[AW-1:OFFW].
- mem_be  out  NB  byte-lane enables.
- mem_wdata  out  XLEN  lane-aligned store data.
- mem_ack  in  1  memory completion; read data is valid in the same cycle.
- mem_rdata  in  XLEN  memory read data.

## Operation
- FSM states: IDLE, ACCESS, RESP. req_ready = 1 only in IDLE.
- IDLE: on req_valid && req_ready, latch we, funct3, addr and wdata, then check legality:
  - Illegal when size==3 and XLEN==32.
  - Illegal when funct3[2]==1 on a store.
  - Illegal when funct3[2]==1 and size equals log2(NB) (e.g. LWU on XLEN=32).
  - Misaligned when addr[size-1:0] != 0.
  - Illegal or misaligned: go to RESP with err=1; no memory access is issued.
  - Otherwise: go to ACCESS and clear the timeout counter.
- ACCESS: mem_req=1, and mem_we/mem_addr/mem_be/mem_wdata are stable throughout.
  - mem_be = ((1<<(1<<size))-1) << off, where off = addr[OFFW-1:0].
  - mem_wdata = req_wdata << (8*off).
  - mem_ack=1 on a rising edge: for loads, capture mem_rdata; go to RESP with err=0.
  - Counter reaches TIMEOUT without ack: go to RESP with err=1.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
  - Load data: (captured >> 8*off) truncated to 8<<size bits, then sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1) to XLEN.
- mem_ack outside ACCESS is ignored; a late ack after timeout has no effect.
- Outside ACCESS, mem_req, mem_we and mem_be are 0.

## Timing
- Reset (rst low): state = IDLE, and every output is 0, including req_ready. req_ready rises in the first cycle after rst deasserts.
- Reset mid-transaction: the transaction is aborted, and mem_req drops asynchronously with rst. No response is produced.
- Accept edge = cycle 0. mem_req is asserted from cycle 1.
- Ack sampled at cycle k (k≥1): rsp_valid in cycle k+1, and req_ready again in cycle k+2. Minimum load/store latency is 2 cycles from accept to rsp_valid.
- Error path for illegal/misaligned requests: rsp_valid with rsp_err in cycle 1, and no mem_req.
- Timeout: mem_req is held for exactly TIMEOUT cycles (cycles 1..TIMEOUT). rsp_valid and rsp_err are asserted in cycle TIMEOUT+1.
- No back-pressure on the response; the core must consume rsp_valid in its cycle.
- req_valid while req_ready=0 is ignored. No queuing.

## Test plan
- Aligned LW, XLEN=32, addr=0x010, memory word 0xDEADBEEF, ack in cycle 1 → mem_addr=0x004, mem_be=4'b1111, rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid in cycle 2.
- LB and LBU at addr=0x013 with word 0x80FF7F01 → mem_be=4'b1000. LB returns 0xFFFFFF80; LBU returns 0x00000080.
- SH addr=0x006, wdata=0x1234ABCD → mem_be=4'b1100, mem_wdata=0xABCD0000, mem_we=1, rsp_rdata=0.
- LW at addr=0x002 and SD on XLEN=32 → rsp_err=1 in cycle 1, and mem_req never asserts.
- TIMEOUT=3, ack never arrives → mem_req high in cycles 1–3, rsp_valid and rsp_err in cycle 4. An ack in cycle 5 is ignored.
- rst pulled low in cycle 2 of ACCESS → mem_req=0 immediately, no rsp_valid. After release, req_ready=1 and a new LW completes normally.
